mem_fetch_unit: RTL and testbench
=================================

# mem_fetch_unit

Memory-access stage of the multicycle MIPS core, directly upstream of the control unit. Serves the control FSM's fetch, load and store requests against a single unified memory port with variable-latency ready/ack handshake. Holds the Instruction Register (IR) and Memory Data Register (MDR). Drives Opcode/Funct and the remaining instruction fields to the control unit and datapath, and raises Stall so the control FSM holds its state while memory is busy.

## Interface
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory data and instruction width
- Opcode_Size, 6, opcode field width (IR[31:26])
- Rtypr_Funct_Size, 6, funct field width (IR[5:0])
- TIMEOUT, 16, maximum wait cycles for mem_ack; must be ≥ 2
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- PC  in  ADDR_WIDTH  program counter, address source when IorD=0
- ALUOut  in  ADDR_WIDTH  ALU result register, address source when IorD=1
- WriteData  in  DATA_WIDTH  store data (B register)
- IorD  in  1  address select from control FSM
- IRWrite  in  1  fetch request; result goes to IR
- MemRead  in  1  load request; result goes to MDR
- MemWrite  in  1  store request
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_WIDTH  latched access address
- mem_wdata  out  DATA_WIDTH  latched store data
- mem_rdata  in  DATA_WIDTH  read data, valid in the mem_ack cycle
- mem_ack  in  1  access complete; ignored unless mem_req=1
- Instr  out  DATA_WIDTH  IR contents
- Opcode  out  Opcode_Size  IR[31:26], to control unit
- Funct  out  Rtypr_Funct_Size  IR[5:0], to control unit
- Rs, Rt, Rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- Imm  out  16  IR[15:0]
- Data  out  DATA_WIDTH  MDR contents
- Stall  out  1  control FSM must hold its state while high
- Mem_Err  out  1  sticky error flag (misaligned access or timeout)

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: a request is any of MemWrite, IRWrite, MemRead. Priority when several are high: MemWrite > IRWrite > MemRead.
- On a request in IDLE:
  - Latch address (IorD ? ALUOut : PC), kind (fetch/load/store) and WriteData.
  - If address[1:0] ≠ 0: set Mem_Err and go to DONE. No memory request is issued.
  - Otherwise go to BUSY.
- BUSY:
  - mem_req=1; mem_we=1 only for store.
  - When mem_ack arrives: fetch writes mem_rdata to IR, load writes mem_rdata to MDR, store changes neither. Go to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - Request inputs are ignored; the FSM is still presenting the request it just completed.
- Stall = (IDLE & request) | BUSY. It is low in DONE.
- Timeout (when compiled in): wait counter clears on IDLE→BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT: set Mem_Err, drop mem_req, go to DONE, leave IR/MDR unchanged.
- Mem_Err clears only on reset.
- Reset values: state IDLE; IR, MDR, mem_addr, mem_wdata, counter = 0; mem_req, mem_we, Stall, Mem_Err = 0. Derived field outputs are therefore 0.
- Reset mid-access drops mem_req asynchronously. A late mem_ack after reset is ignored.

## Timing
- Request seen in cycle N → mem_req high from N+1.
- mem_ack in cycle N+k → IR/MDR updated at that edge; DONE in N+k+1, with Stall low.
- Minimum access, with ack in the first BUSY cycle: 2 stall cycles, then 1 DONE cycle.
- Misaligned access: 1 stall cycle, then DONE.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after DONE.
- mem_addr, mem_we and mem_wdata are stable throughout BUSY.

## Configuration
- MEM_TIMEOUT_EN
  - Defined: wait counter and timeout path present, as described under Operation.
  - Undefined: no counter; BUSY waits indefinitely for mem_ack. Mem_Err is then set only by misaligned accesses. TIMEOUT is unused.

## Structure
- mem_fetch_pkg holds:
  - state enum (IDLE/BUSY/DONE)
  - access-kind enum (FETCH/LOAD/STORE)
  - IR field bit-position constants (opcode, rs, rt, rd, imm, funct)
- One sub-module, mem_wait_timer: clear/enable counter with TIMEOUT compare and an expired output. Instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Fetch: PC=0x40, IorD=0, IRWrite=1, mem_rdata=0x012A4020, ack on 3rd BUSY cycle → mem_addr=0x40, mem_we=0, Stall high 4 cycles, Opcode=0, Funct=0x20, Rd=8.
- Store: IorD=1, ALUOut=0x100, WriteData=0xDEADBEEF, MemWrite=1 → mem_we=1, mem_wdata=0xDEADBEEF; IR and MDR unchanged.
- Load then fetch back-to-back: ALUOut=0x200, rdata=0x1234 → Data=0x1234; next fetch request accepted in the cycle right after DONE.
- Misaligned: ALUOut=0x102, MemRead=1 → mem_req never asserted, Mem_Err=1, Stall high exactly 1 cycle.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=16), no ack → mem_req drops after 16 BUSY cycles, Mem_Err=1, IR unchanged.
- rst low during BUSY → mem_req=0 immediately, all outputs at reset values; a subsequent ack causes no register update.

Source files
------------

// File: rtl/mem_fetch_pkg.sv
// Shared types for the memory-access stage: FSM states, access kinds, IR field positions.
// Pure definitions; no logic.
package mem_fetch_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} kind_e;

  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int FN_LO  = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; expired_o pulses combinationally in the
// last permitted wait cycle, so the requester sees exactly TIMEOUT cycles of wait before giving up.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // The edge that raises the count to TIMEOUT is the same edge that leaves BUSY.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_fetch_unit.sv
// Multicycle MIPS memory stage: serves fetch/load/store over a req/ack port, holds IR and MDR.
// Optional wait-cycle timeout is compiled in with MEM_TIMEOUT_EN.
module mem_fetch_unit
  import mem_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int Opcode_Size      = 6,
  parameter int Rtypr_Funct_Size = 6,
  parameter int TIMEOUT          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       PC,
  input  logic [ADDR_WIDTH-1:0]       ALUOut,
  input  logic [DATA_WIDTH-1:0]       WriteData,
  input  logic                        IorD,
  input  logic                        IRWrite,
  input  logic                        MemRead,
  input  logic                        MemWrite,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_ack,
  output logic [DATA_WIDTH-1:0]       Instr,
  output logic [Opcode_Size-1:0]      Opcode,
  output logic [Rtypr_Funct_Size-1:0] Funct,
  output logic [4:0]                  Rs,
  output logic [4:0]                  Rt,
  output logic [4:0]                  Rd,
  output logic [15:0]                 Imm,
  output logic [DATA_WIDTH-1:0]       Data,
  output logic                        Stall,
  output logic                        Mem_Err
);

  state_e                state_q, state_d;
  kind_e                 kind_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic                  err_q;

  logic                  req_any;
  kind_e                 req_kind;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  misal;
  logic                  expired;

  assign req_any  = MemWrite | IRWrite | MemRead;
  assign req_kind = MemWrite ? STORE : (IRWrite ? FETCH : LOAD);
  assign req_addr = IorD ? ALUOut : PC;
  assign misal    = (req_addr[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     ((state_q == IDLE) && req_any && !misal),
    .en_i      ((state_q == BUSY) && !mem_ack),
    .expired_o (expired)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = misal ? DONE : BUSY;
      BUSY:    if (mem_ack || expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == BUSY);
    mem_we  = (state_q == BUSY) && (kind_q == STORE);
    Stall   = ((state_q == IDLE) && req_any) || (state_q == BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q  <= FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_any) begin
        kind_q  <= req_kind;
        addr_q  <= req_addr;
        wdata_q <= WriteData;
        if (misal) err_q <= 1'b1;
      end
      if ((state_q == BUSY) && mem_ack) begin
        if (kind_q == FETCH) ir_q  <= mem_rdata;
        if (kind_q == LOAD)  mdr_q <= mem_rdata;
      end
      if (expired) err_q <= 1'b1;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Instr     = ir_q;
  assign Data      = mdr_q;
  assign Mem_Err   = err_q;
  assign Opcode    = ir_q[OPC_LO +: Opcode_Size];
  assign Funct     = ir_q[FN_LO +: Rtypr_Funct_Size];
  assign Rs        = ir_q[RS_HI:RS_LO];
  assign Rt        = ir_q[RT_HI:RT_LO];
  assign Rd        = ir_q[RD_HI:RD_LO];
  assign Imm       = ir_q[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Self-checking bench for mem_fetch_unit: vector table of accesses plus reset and timeout sequences.
module tb_mem_fetch_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, ALUOut, WriteData, mem_rdata;
  logic        IorD, IRWrite, MemRead, MemWrite, mem_ack;
  logic        mem_req, mem_we, Stall, Mem_Err;
  logic [31:0] mem_addr, mem_wdata, Instr, Data;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] Imm;

  always #5 clk = ~clk;

  mem_fetch_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .Instr(Instr), .Opcode(Opcode),
    .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm), .Data(Data),
    .Stall(Stall), .Mem_Err(Mem_Err)
  );

  typedef struct packed {
    logic [2:0]  req;   // {MemWrite, IRWrite, MemRead}
    logic        iord;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [3:0]  dly;   // BUSY cycle in which ack is given
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        misal;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } sb_t;

  vec_t        vec [8];
  sb_t         sb_q [$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_ir = '0;
  logic [31:0] m_mdr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_req();
    IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic check_fields();
    chk("instr", Instr, m_ir);
    chk("data", Data, m_mdr);
    chk("opcode", 32'(Opcode), 32'(m_ir[31:26]));
    chk("funct", 32'(Funct), 32'(m_ir[5:0]));
    chk("rs", 32'(Rs), 32'(m_ir[25:21]));
    chk("rt", 32'(Rt), 32'(m_ir[20:16]));
    chk("rd", 32'(Rd), 32'(m_ir[15:11]));
    chk("imm", 32'(Imm), 32'(m_ir[15:0]));
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    sb_t e;
    int  stalls;
    int  cyc;
    {MemWrite, IRWrite, MemRead} = v.req;
    IorD = v.iord; PC = v.pc; ALUOut = v.alu; WriteData = v.wd;
    if (!v.misal) sb_q.push_back('{v.exp_addr, v.exp_we, v.wd});
    #1;
    stalls = Stall ? 1 : 0;
    chk("stall_on_req", 32'(Stall), 32'd1);
    chk("req_idle", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    clear_req();
    if (v.misal) begin
      chk("misal_req", 32'(mem_req), 32'd0);
      chk("misal_stall_cycles", 32'(stalls), 32'd1);
    end else begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
        e = '0;
      end else begin
        e = sb_q.pop_front();
      end
      cyc = 0;
      while (Stall && cyc < 64) begin
        cyc++;
        stalls++;
        chk("busy_req", 32'(mem_req), 32'd1);
        chk("busy_addr", mem_addr, e.addr);
        chk("busy_we", 32'(mem_we), 32'(e.we));
        chk("busy_wdata", mem_wdata, e.wd);
        if (cyc == int'(v.dly)) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      if (v.req[2])      begin end
      else if (v.req[1]) m_ir  = v.rdata;
      else               m_mdr = v.rdata;
      chk("stall_cycles", 32'(stalls), 32'(v.dly) + 32'd1);
    end
    chk("done_stall", 32'(Stall), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("err", 32'(Mem_Err), 32'(v.exp_err));
    check_fields();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    //         req     iord  pc         alu        wd            rdata         dly   addr       we    mis   err
    vec[0] = '{3'b010, 1'b0, 32'h40,    32'h999,   32'h11,       32'h012A4020, 4'd3, 32'h40,    1'b0, 1'b0, 1'b0};
    vec[1] = '{3'b100, 1'b1, 32'h44,    32'h100,   32'hDEADBEEF, 32'hFFFFFFFF, 4'd1, 32'h100,   1'b1, 1'b0, 1'b0};
    vec[2] = '{3'b001, 1'b1, 32'h44,    32'h200,   32'h22,       32'h00001234, 4'd2, 32'h200,   1'b0, 1'b0, 1'b0};
    vec[3] = '{3'b010, 1'b0, 32'h44,    32'h200,   32'h33,       32'h8C220004, 4'd1, 32'h44,    1'b0, 1'b0, 1'b0};
    vec[4] = '{3'b111, 1'b1, 32'h48,    32'h300,   32'hCAFEF00D, 32'h00000055, 4'd2, 32'h300,   1'b1, 1'b0, 1'b0};
    vec[5] = '{3'b011, 1'b0, 32'h48,    32'h304,   32'h44,       32'hAABBCCDD, 4'd1, 32'h48,    1'b0, 1'b0, 1'b0};
    vec[6] = '{3'b001, 1'b1, 32'h4C,    32'h102,   32'h55,       32'h0BADF00D, 4'd1, 32'h102,   1'b0, 1'b1, 1'b1};
    vec[7] = '{3'b001, 1'b1, 32'h4C,    32'h204,   32'h66,       32'h00000077, 4'd1, 32'h204,   1'b0, 1'b0, 1'b1};

    rst = 1'b0; PC = '0; ALUOut = '0; WriteData = '0; IorD = 1'b0;
    clear_req(); mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_err", 32'(Mem_Err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    check_fields();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vec[i]);
      if (i == 0) begin
        chk("tp_opcode", 32'(Opcode), 32'h0);
        chk("tp_funct", 32'(Funct), 32'h20);
        chk("tp_rd", 32'(Rd), 32'd8);
      end
    end

    // Reset in the middle of a BUSY fetch, then a stray ack.
    IorD = 1'b0; PC = 32'h60; IRWrite = 1'b1;
    @(posedge clk); #1;
    clear_req();
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    m_ir = '0; m_mdr = '0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_stall", 32'(Stall), 32'd0);
    chk("mid_rst_err", 32'(Mem_Err), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    check_fields();
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_stall", 32'(Stall), 32'd0);
    check_fields();

`ifdef MEM_TIMEOUT_EN
    IorD = 1'b0; PC = 32'h80; IRWrite = 1'b1;
    @(posedge clk); #1;
    clear_req();
    cyc = 0;
    while (mem_req && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("timeout_cycles", 32'(cyc), 32'(TO));
    chk("timeout_err", 32'(Mem_Err), 32'd1);
    chk("timeout_stall", 32'(Stall), 32'd0);
    check_fields();
    @(posedge clk); #1;
`else
    cyc = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
